// File: rtl/if_id_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : if_id_buffer_pkg
// Description : Shared CPU defines: instruction field positions, NOP word and
//               the IF/ID buffer entry layout.
// Revision    : 1.0 - initial release
// ============================================================================
package if_id_buffer_pkg;

  localparam int unsigned c_opHi    = 31;
  localparam int unsigned c_opLo    = 26;
  localparam int unsigned c_rsHi    = 25;
  localparam int unsigned c_rsLo    = 21;
  localparam int unsigned c_rtHi    = 20;
  localparam int unsigned c_rtLo    = 16;
  localparam int unsigned c_rdHi    = 15;
  localparam int unsigned c_rdLo    = 11;
  localparam int unsigned c_saHi    = 10;
  localparam int unsigned c_saLo    = 6;
  localparam int unsigned c_functHi = 5;
  localparam int unsigned c_functLo = 0;
  localparam int unsigned c_immHi   = 15;
  localparam int unsigned c_immLo   = 0;

  localparam logic [31:0] c_nop = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        adel;
    logic        delaySlot;
  } ifEntry_t;

endpackage
`default_nettype wire

// File: rtl/if_id_buffer.sv
`default_nettype none
// ============================================================================
// Module      : if_id_buffer
// Description : Two-entry FIFO between fetch and decode with registered head
//               outputs, stall hold and flush.
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_buffer
  import if_id_buffer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        validF,
  input  logic [31:0] pcF,
  input  logic [31:0] instrF,
  input  logic        adelF,
  input  logic        is_in_delayslotF,
  output logic        readyF,
  input  logic        stallD,
  input  logic        flushD,
  output logic        validD,
  output logic [31:0] pcD,
  output logic [31:0] instrD,
  output logic [5:0]  opD,
  output logic [5:0]  functD,
  output logic [4:0]  rsD,
  output logic [4:0]  rtD,
  output logic [4:0]  rdD,
  output logic [4:0]  saD,
  output logic [15:0] immD,
  output logic        adelD,
  output logic        is_in_delayslotD
);

  ifEntry_t    r_entry [2];
  logic [1:0]  r_valid;
  logic [1:0]  r_count;
  logic        r_wrPtr;
  logic        r_rdPtr;

  logic        w_push;
  logic        w_pop;
  ifEntry_t    w_head;

  assign readyF = (r_count < 2'd2);
  assign validD = r_valid[r_rdPtr];
  assign w_push = validF & readyF & ~flushD;
  assign w_pop  = validD & ~stallD & ~flushD;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 2'b00;
      r_count <= 2'd0;
      r_wrPtr <= 1'b0;
      r_rdPtr <= 1'b0;
    end else if (flushD) begin
      r_valid <= 2'b00;
      r_count <= 2'd0;
      r_wrPtr <= 1'b0;
      r_rdPtr <= 1'b0;
    end else begin
      // push and pop never target the same slot: push needs count<2, pop needs count>0
      if (w_push) begin
        r_valid[r_wrPtr] <= 1'b1;
        r_wrPtr          <= ~r_wrPtr;
      end
      if (w_pop) begin
        r_valid[r_rdPtr] <= 1'b0;
        r_rdPtr          <= ~r_rdPtr;
      end
      if (w_push && !w_pop)
        r_count <= r_count + 2'd1;
      else if (w_pop && !w_push)
        r_count <= r_count - 2'd1;
    end
  end

  // Payload is not reset; every output below is gated by validD.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_entry[r_wrPtr] <= '{pc: pcF, instr: instrF, adel: adelF, delaySlot: is_in_delayslotF};
    end
  end

  assign w_head = r_entry[r_rdPtr];

  assign pcD              = validD ? w_head.pc    : 32'h0;
  assign instrD           = validD ? w_head.instr : c_nop;
  assign adelD            = validD & w_head.adel;
  assign is_in_delayslotD = validD & w_head.delaySlot;

  assign opD    = instrD[c_opHi:c_opLo];
  assign rsD    = instrD[c_rsHi:c_rsLo];
  assign rtD    = instrD[c_rtHi:c_rtLo];
  assign rdD    = instrD[c_rdHi:c_rdLo];
  assign saD    = instrD[c_saHi:c_saLo];
  assign functD = instrD[c_functHi:c_functLo];
  assign immD   = instrD[c_immHi:c_immLo];

endmodule
`default_nettype wire

// File: tb/tb_if_id_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_id_buffer
// Description : Directed self-checking bench for the IF/ID buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_id_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        validF;
  logic [31:0] pcF;
  logic [31:0] instrF;
  logic        adelF;
  logic        is_in_delayslotF;
  logic        readyF;
  logic        stallD;
  logic        flushD;
  logic        validD;
  logic [31:0] pcD;
  logic [31:0] instrD;
  logic [5:0]  opD;
  logic [5:0]  functD;
  logic [4:0]  rsD;
  logic [4:0]  rtD;
  logic [4:0]  rdD;
  logic [4:0]  saD;
  logic [15:0] immD;
  logic        adelD;
  logic        is_in_delayslotD;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  if_id_buffer dut (
    .clk              (clk),
    .rst              (rst),
    .validF           (validF),
    .pcF              (pcF),
    .instrF           (instrF),
    .adelF            (adelF),
    .is_in_delayslotF (is_in_delayslotF),
    .readyF           (readyF),
    .stallD           (stallD),
    .flushD           (flushD),
    .validD           (validD),
    .pcD              (pcD),
    .instrD           (instrD),
    .opD              (opD),
    .functD           (functD),
    .rsD              (rsD),
    .rtD              (rtD),
    .rdD              (rdD),
    .saD              (saD),
    .immD             (immD),
    .adelD            (adelD),
    .is_in_delayslotD (is_in_delayslotD)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic ad, input logic ds);
    validF           = v;
    pcF              = pc;
    instrF           = ins;
    adelF            = ad;
    is_in_delayslotF = ds;
  endtask

  initial begin
    rst    = 1'b0;
    stallD = 1'b0;
    flushD = 1'b0;
    drive(1'b1, 32'h1234_5678, 32'hDEAD_BEEF, 1'b1, 1'b1);

    // Reset held with fetch presenting data
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_readyF", {31'b0, readyF}, 32'd1);
      check("rst_validD", {31'b0, validD}, 32'd0);
      check("rst_instrD", instrD, 32'h0);
    end
    check("rst_pcD", pcD, 32'h0);
    check("rst_adelD", {31'b0, adelD}, 32'd0);

    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    check("idle_validD", {31'b0, validD}, 32'd0);

    // Single pass
    drive(1'b1, 32'hBFC0_0000, 32'h2408_0001, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("pass_validD", {31'b0, validD}, 32'd1);
    check("pass_pcD", pcD, 32'hBFC0_0000);
    check("pass_opD", {26'b0, opD}, 32'h09);
    check("pass_rtD", {27'b0, rtD}, 32'd8);
    check("pass_rsD", {27'b0, rsD}, 32'd0);
    check("pass_immD", {16'b0, immD}, 32'h0001);
    check("pass_flags", {30'b0, adelD, is_in_delayslotD}, 32'd0);
    step();
    check("pass_drain_validD", {31'b0, validD}, 32'd0);
    check("pass_drain_instrD", instrD, 32'h0);

    // Fill under stall
    stallD = 1'b1;
    drive(1'b1, 32'h0000_0100, 32'h8C22_0004, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h0000_0104, 32'h0085_1020, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("fill_readyF", {31'b0, readyF}, 32'd0);
    check("fill_pcD", pcD, 32'h0000_0100);
    check("fill_opD", {26'b0, opD}, 32'h23);
    check("fill_rsD", {27'b0, rsD}, 32'd1);
    check("fill_rtD", {27'b0, rtD}, 32'd2);
    drive(1'b1, 32'h0000_0999, 32'h9999_9999, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("hold_readyF", {31'b0, readyF}, 32'd0);
    check("hold_pcD", pcD, 32'h0000_0100);
    stallD = 1'b0;
    step();
    check("drainB_pcD", pcD, 32'h0000_0104);
    check("drainB_functD", {26'b0, functD}, 32'h20);
    check("drainB_rdD", {27'b0, rdD}, 32'd2);
    check("drainB_rtD", {27'b0, rtD}, 32'd5);
    check("drainB_readyF", {31'b0, readyF}, 32'd1);
    step();
    check("drain_empty", {31'b0, validD}, 32'd0);

    // Flush with push
    stallD = 1'b1;
    drive(1'b1, 32'h0000_0200, 32'h3C01_ABCD, 1'b0, 1'b0);
    step();
    check("preflush_pcD", pcD, 32'h0000_0200);
    check("preflush_immD", {16'b0, immD}, 32'h0000_ABCD);
    flushD = 1'b1;
    drive(1'b1, 32'h0000_0300, 32'h1111_1111, 1'b0, 1'b0);
    step();
    flushD = 1'b0;
    stallD = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("flush_validD", {31'b0, validD}, 32'd0);
    check("flush_instrD", instrD, 32'h0);
    check("flush_readyF", {31'b0, readyF}, 32'd1);
    step();
    check("flush_nodrop_validD", {31'b0, validD}, 32'd0);

    // Push + pop at count=1
    stallD = 1'b1;
    drive(1'b1, 32'h0000_0400, 32'h2042_0005, 1'b0, 1'b0);
    step();
    check("pp_headA", pcD, 32'h0000_0400);
    stallD = 1'b0;
    drive(1'b1, 32'h0000_0404, 32'h0002_10C0, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("pp_headB", pcD, 32'h0000_0404);
    check("pp_saD", {27'b0, saD}, 32'd3);
    check("pp_readyF", {31'b0, readyF}, 32'd1);
    stallD = 1'b1;
    step();
    check("pp_hold", pcD, 32'h0000_0404);
    check("pp_hold_readyF", {31'b0, readyF}, 32'd1);
    stallD = 1'b0;
    step();
    check("pp_empty", {31'b0, validD}, 32'd0);

    // Flag carry
    drive(1'b1, 32'h0000_0500, 32'h0000_0000, 1'b1, 1'b1);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("flag_pcD", pcD, 32'h0000_0500);
    check("flag_adelD", {31'b0, adelD}, 32'd1);
    check("flag_dsD", {31'b0, is_in_delayslotD}, 32'd1);
    step();
    check("flag_gated", {30'b0, adelD, is_in_delayslotD}, 32'd0);

    // Asynchronous reset mid-operation
    stallD = 1'b1;
    drive(1'b1, 32'h0000_0600, 32'h2408_0007, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h0000_0604, 32'h2408_0008, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("prerst_readyF", {31'b0, readyF}, 32'd0);
    #2;
    rst = 1'b0;
    #1;
    check("arst_validD", {31'b0, validD}, 32'd0);
    check("arst_readyF", {31'b0, readyF}, 32'd1);
    step();
    rst    = 1'b1;
    stallD = 1'b0;
    step();
    check("postrst_validD", {31'b0, validD}, 32'd0);
    drive(1'b1, 32'h0000_0700, 32'h0000_0000, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("postrst_pcD", pcD, 32'h0000_0700);
    step();
    check("postrst_empty", {31'b0, validD}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/if_id_buffer.md
IF_ID_BUFFER -- requirements
Module: if_id_buffer

Interface
REQ-001 The block SHALL provide the following ports (name  direction  width  meaning):
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 validF  in  1  fetch presents an instruction this cycle.
REQ-005 pcF  in  32  PC of the presented instruction.
REQ-006 instrF  in  32  instruction word.
REQ-007 adelF  in  1  fetch address-error flag for this instruction.
REQ-008 is_in_delayslotF  in  1  instruction is a delay-slot instruction (driven by the decode controller).
REQ-009 readyF  out  1  buffer can accept a push this cycle.
REQ-010 stallD  in  1  decode holds its current instruction.
REQ-011 flushD  in  1  discard all buffered instructions.
REQ-012 validD  out  1  decode-side head entry is valid.
REQ-013 pcD / instrD  out  32 each  head entry PC and word.
REQ-014 opD, functD  out  6 each  instrD[31:26], instrD[5:0].
REQ-015 rsD, rtD, rdD, saD  out  5 each  instrD[25:21], [20:16], [15:11], [10:6].
REQ-016 immD  out  16  instrD[15:0].
REQ-017 adelD, is_in_delayslotD  out  1 each  head entry flags.

Function
REQ-018 Storage SHALL be a 2-entry FIFO; each entry holds {pc, instr, adel, delayslot}; occupancy count 0..2.
REQ-019 readyF SHALL equal (count < 2) and SHALL NOT depend combinationally on stallD or validF.
REQ-020 Push SHALL occur on a rising edge when validF & readyF & !flushD.
REQ-021 Pop SHALL occur on a rising edge when validD & !stallD & !flushD.
REQ-022 Simultaneous push and pop SHALL leave count unchanged, with the new entry queued behind the remaining one (count=1: head replaced by pushed entry).
REQ-023 Head outputs SHALL be driven from registered storage; an instruction pushed at edge N SHALL be visible on decode outputs during cycle N+1 (latency 1), never combinationally from instrF.
REQ-024 When count=0, validD SHALL be 0, instrD SHALL be 32'h0 (NOP) and all derived fields 0, pcD 0, adelD 0, is_in_delayslotD 0.
REQ-025 flushD SHALL, on the next edge, set count to 0 and invalidate both entries; any push or pop in that cycle SHALL be dropped.
REQ-026 stallD with count=2 SHALL hold both entries and readyF=0 until a pop.
REQ-027 Read/write pointers SHALL be 1 bit each and wrap 1->0.
REQ-028 Entry order SHALL be strict FIFO; no entry SHALL be duplicated or lost except by flushD.

Reset
REQ-029 rst low SHALL asynchronously clear count and both pointers to 0 and entry valid bits to 0; outputs SHALL take REQ-024 values and readyF SHALL be 1.
REQ-030 Entry payload registers need not be reset; outputs SHALL be gated by validD.
REQ-031 Reset deasserted mid-operation SHALL start from the empty state; no partial entry survives.

Structure
REQ-032 Instruction field bit positions (op, funct, rs, rt, rd, sa, imm) and the NOP constant SHALL live in the shared CPU defines package.
REQ-033 The block SHALL be one module with no sub-modules; field extraction is plain slicing of the head entry.

Verification
REQ-034 Reset: hold rst=0 with validF=1 -> readyF=1, validD=0, instrD=0 throughout.
REQ-035 Single pass: push pcF=32'hBFC00000, instrF=32'h24080001 at edge 1, stallD=0 -> cycle 2 validD=1, opD=6'h09, rtD=5'd8, immD=16'h0001; cycle 3 validD=0.
REQ-036 Fill under stall: stallD=1, push A then B -> count=2, readyF=0, validD shows A; release stallD -> A then B in order, readyF=1 one cycle after first pop.
REQ-037 Flush with push: count=1, flushD=1 with validF=1 -> next cycle validD=0, count=0; pushed word never appears.
REQ-038 Push+pop at count=1: head A, push B, stallD=0 -> next cycle head B, count=1.
REQ-039 Flag carry: push with adelF=1, is_in_delayslotF=1 -> adelD=1, is_in_delayslotD=1 on the same cycle its pcD appears.
